pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rstn  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: dbg_run, dbg_step, dbg_halt  in  1 each  one-cycle debug command pulses.
REQ-004 SHALL provide: bp_we  in  1, bp_idx  in  1, bp_addr  in  32, bp_valid  in  1; these write one breakpoint entry.
REQ-005 SHALL provide: if_pc  in  32  PC currently held in the fetch stage.
REQ-006 SHALL provide: id_rs1, id_rs2  in  5 each, and id_use_rs1, id_use_rs2  in  1 each; these are the decode-stage source registers and their use flags.
REQ-007 SHALL provide: ex_mem_read  in  1 and ex_rd  in  5; these identify a load in EX and its destination register.
REQ-008 SHALL provide: br_jal_success, alu_to_pc  in  1 each  EX-stage redirect indicators.
REQ-009 SHALL provide: stall_if, stall_id  out  1 each  hold the PC and the IF/ID register.
REQ-010 SHALL provide: flush_id, flush_ex  out  1 each  bubble the IF/ID and ID/EX registers.
REQ-011 SHALL provide: freeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
REQ-012 SHALL provide: state  out  2 (HALT=0, RUN=1, STEP=2), and bp_hit  out  1.
REQ-013 SHALL provide: cycle_cnt, stall_cnt  out  32 each.

Function
REQ-014 SHALL implement an FSM with states HALT, RUN and STEP; the state output SHALL be registered.
REQ-015 In HALT, priority SHALL be dbg_step > dbg_run: dbg_step -> STEP; dbg_run -> RUN with bp_skip set; dbg_halt -> no effect.
REQ-016 In RUN: dbg_halt -> HALT; breakpoint hit -> HALT with bp_hit set; dbg_run and dbg_step -> ignored.
REQ-017 In STEP: the pipeline SHALL advance exactly one cycle, then go to HALT unconditionally; all commands and breakpoints SHALL be ignored.
REQ-018 pipe_en SHALL be 1 in STEP, and in RUN when neither dbg_halt nor a breakpoint hit occurs this cycle; pipe_en SHALL be 0 otherwise.
REQ-019 A breakpoint hit SHALL occur when state==RUN, bp_skip==0, and if_pc equals the bp_addr of any entry whose bp_valid is 1.
REQ-020 bp_skip SHALL clear after the first RUN cycle, so resuming at a breakpoint PC SHALL proceed past it.
REQ-021 bp_hit SHALL be cleared on any transition out of HALT.
REQ-022 Breakpoint writes (bp_we) SHALL take effect on the next edge in any state; a comparison SHALL use the old entry on the write cycle.
REQ-023 load_use SHALL equal ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-024 redirect SHALL equal br_jal_success | alu_to_pc.
REQ-025 Outputs SHALL be combinational. With pipe_en=0: freeze=1, stall_if=stall_id=1, and both flushes=0.
REQ-026 With pipe_en=1 and redirect=1: flush_id=flush_ex=1 and both stalls=0; redirect SHALL take priority over load_use.
REQ-027 With pipe_en=1, load_use=1 and redirect=0: stall_if=stall_id=1, flush_ex=1 and flush_id=0, giving a one-cycle stall; the stall SHALL release when the load leaves EX.
REQ-028 With pipe_en=1 and no hazard, all control outputs SHALL be 0.
REQ-029 cycle_cnt SHALL increment on each pipe_en cycle; stall_cnt SHALL increment on each cycle that applies the REQ-027 condition; both SHALL wrap modulo 2^32.

Reset
REQ-030 rstn=0 SHALL immediately force: state=HALT, bp_hit=0, bp_skip=0, both breakpoint entries invalid with bp_addr=0, and both counters 0.
REQ-031 Consequently, during reset freeze=1, stall_if=stall_id=1 and flush_id=flush_ex=0.
REQ-032 Reset asserted mid-RUN or mid-STEP SHALL abort the state to HALT within the same cycle; no counter increment SHALL occur on that edge.

Verification
REQ-033 Reset then dbg_step pulse -> one cycle with freeze=0, then state=HALT, cycle_cnt=1.
REQ-034 RUN with entry0={valid, 0x0000_0010}; if_pc reaches 0x10 -> freeze=1 that cycle, state=HALT, bp_hit=1; dbg_run -> runs past 0x10, bp_hit=0.
REQ-035 RUN, ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> stall_if=stall_id=flush_ex=1 for one cycle, stall_cnt +1.
REQ-036 RUN with load_use and br_jal_success both 1 -> flush_id=flush_ex=1, stall_if=0, stall_cnt unchanged.
REQ-037 RUN with dbg_halt and a breakpoint hit in the same cycle -> HALT; then dbg_run and dbg_step in the same cycle -> STEP.
REQ-038 cycle_cnt preloaded near 0xFFFF_FFFF via running, then one more pipe_en cycle -> wraps to 0; rstn pulse mid-RUN -> all outputs equal their reset values.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Signal bundle between the pipeline/debug front end and the
//               pipeline controller.
//               master : drives debug commands, breakpoint writes and the
//                        hazard inputs (IF PC, ID sources, EX load/redirect);
//                        receives the stall/flush/freeze controls, FSM state,
//                        breakpoint-hit flag and the cycle/stall counters.
//               slave  : the controller side (pipe_ctrl).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    logic        dbg_run;
    logic        dbg_step;
    logic        dbg_halt;
    logic        bp_we;
    logic        bp_idx;
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic [31:0] if_pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        br_jal_success;
    logic        alu_to_pc;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        flush_ex;
    logic        freeze;
    logic [1:0]  state;
    logic        bp_hit;
    logic [31:0] cycle_cnt;
    logic [31:0] stall_cnt;

    modport master (
        output dbg_run, dbg_step, dbg_halt,
        output bp_we, bp_idx, bp_addr, bp_valid,
        output if_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_mem_read, ex_rd, br_jal_success, alu_to_pc,
        input  stall_if, stall_id, flush_id, flush_ex, freeze,
        input  state, bp_hit, cycle_cnt, stall_cnt
    );

    modport slave (
        input  dbg_run, dbg_step, dbg_halt,
        input  bp_we, bp_idx, bp_addr, bp_valid,
        input  if_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_mem_read, ex_rd, br_jal_success, alu_to_pc,
        output stall_if, stall_id, flush_id, flush_ex, freeze,
        output state, bp_hit, cycle_cnt, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard and debug controller. A HALT/RUN/STEP debug
//               FSM with two PC breakpoints gates the pipeline; when enabled,
//               EX redirects flush IF/ID and ID/EX, and load-use hazards stall
//               IF/ID for one cycle while bubbling ID/EX.
//               Ports: clk  - clock, rising edge
//                      rstn - asynchronous active-low reset
//                      bus  - pipe_ctrl_if.slave (commands, hazard inputs,
//                             pipeline controls, state and counters)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
    input  logic        clk,
    input  logic        rstn,
    pipe_ctrl_if.slave  bus
);

    localparam logic [1:0] c_st_halt = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_step = 2'd2;
    localparam int         c_num_bp  = 2;

    logic [1:0]                  state_q, state_d;
    logic                        bp_skip_q, bp_skip_d;
    logic                        bp_hit_q, bp_hit_d;
    logic [c_num_bp-1:0]         bp_valid_q, bp_valid_d;
    logic [c_num_bp-1:0][31:0]   bp_addr_q, bp_addr_d;
    logic [31:0]                 cycle_cnt_q, cycle_cnt_d;
    logic [31:0]                 stall_cnt_q, stall_cnt_d;

    logic [c_num_bp-1:0]         w_bp_match;
    logic                        w_bp_hit;
    logic                        w_load_use;
    logic                        w_redirect;
    logic                        w_pipe_en;
    logic                        w_stall_apply;

    // Compare against the registered entries, so a write on this cycle
    // only affects comparisons from the next cycle onward.
    for (genvar i = 0; i < c_num_bp; i++) begin : g_bp_match
        assign w_bp_match[i] = bp_valid_q[i] && (bus.if_pc == bp_addr_q[i]);
    end

    // bp_skip lets a resume from a breakpoint PC execute past it.
    assign w_bp_hit   = (state_q == c_st_run) && !bp_skip_q && (|w_bp_match);
    assign w_load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                         (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign w_redirect = bus.br_jal_success || bus.alu_to_pc;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= c_st_halt;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_halt: begin
                if (bus.dbg_step)     state_d = c_st_step;
                else if (bus.dbg_run) state_d = c_st_run;
            end
            c_st_run: begin
                if (bus.dbg_halt || w_bp_hit) state_d = c_st_halt;
            end
            c_st_step: state_d = c_st_halt;
            default:   state_d = c_st_halt;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_pipe_en = (state_q == c_st_step) ||
                    ((state_q == c_st_run) && !bus.dbg_halt && !w_bp_hit);
        w_stall_apply = 1'b0;
        bus.freeze    = 1'b0;
        bus.stall_if  = 1'b0;
        bus.stall_id  = 1'b0;
        bus.flush_id  = 1'b0;
        bus.flush_ex  = 1'b0;
        if (!w_pipe_en) begin
            bus.freeze   = 1'b1;
            bus.stall_if = 1'b1;
            bus.stall_id = 1'b1;
        end else if (w_redirect) begin
            // Redirect wins: the stalled instruction is on the wrong path.
            bus.flush_id = 1'b1;
            bus.flush_ex = 1'b1;
        end else if (w_load_use) begin
            w_stall_apply = 1'b1;
            bus.stall_if  = 1'b1;
            bus.stall_id  = 1'b1;
            bus.flush_ex  = 1'b1;
        end
        bus.state     = state_q;
        bus.bp_hit    = bp_hit_q;
        bus.cycle_cnt = cycle_cnt_q;
        bus.stall_cnt = stall_cnt_q;
    end

    // ---------------- Debug flags, breakpoints, counters ----------------
    always_comb begin
        bp_skip_d = (state_q == c_st_halt) && !bus.dbg_step && bus.dbg_run;

        bp_hit_d = bp_hit_q;
        if (w_bp_hit) begin
            bp_hit_d = 1'b1;
        end else if ((state_q == c_st_halt) && (state_d != c_st_halt)) begin
            bp_hit_d = 1'b0;
        end

        bp_valid_d = bp_valid_q;
        bp_addr_d  = bp_addr_q;
        if (bus.bp_we) begin
            bp_valid_d[bus.bp_idx] = bus.bp_valid;
            bp_addr_d[bus.bp_idx]  = bus.bp_addr;
        end

        cycle_cnt_d = cycle_cnt_q + {31'd0, w_pipe_en};
        stall_cnt_d = stall_cnt_q + {31'd0, w_stall_apply};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bp_skip_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
            bp_valid_q  <= '0;
            bp_addr_q   <= '0;
            cycle_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            bp_skip_q   <= bp_skip_d;
            bp_hit_q    <= bp_hit_d;
            bp_valid_q  <= bp_valid_d;
            bp_addr_q   <= bp_addr_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire
